flit_injector: RTL and testbench
================================

// Module: flit_injector
// PURPOSE
//  Local-port network interface transmitter: turns packet requests (descriptor + payload words) into
//  wormhole flits and drives a router inport (flit_inport_*, valid_in_*), obeying buffer_on flow control.
//  Sits between a core/traffic source and the router local inport; the packet sender of the fabric.
// PARAMETERS
//  X_CURRENT  3'b000  X coordinate of this node, inserted as source X in head flits
//  Y_CURRENT  3'b000  Y coordinate of this node, inserted as source Y in head flits
// PORTS
//  clk         in   1   clock, all logic on posedge
//  rst         in   1   synchronous reset, active-low (0 = reset)
//  pkt_valid   in   1   packet descriptor valid
//  pkt_ready   out  1   descriptor accepted when pkt_valid & pkt_ready
//  pkt_dest_x  in   3   destination X
//  pkt_dest_y  in   3   destination Y
//  pkt_len     in   4   payload flits following head (0..15)
//  data_valid  in   1   payload word valid
//  data_ready  out  1   payload word consumed when data_valid & data_ready
//  data_in     in   60  payload word
//  buffer_on   in   1   router inport has space; 1 at a posedge permits one flit at that edge
//  flit_out    out  64  flit to router inport
//  valid_out   out  1   flit_out valid this cycle (exactly one flit per high cycle)
//  busy        out  1   packet in progress (state != IDLE)
//  pkt_count   out  16  packets fully sent (tail emitted), wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Flit format: [63:62] type 00=head 01=body 10=tail 11=head-tail; [61:60]=pkt_count[1:0] at packet start.
//   head/head-tail [59:0]: [59:57] dest X, [56:54] dest Y, [53:51] X_CURRENT, [50:48] Y_CURRENT,
//   [47:44] pkt_len, [43:0] zero. body/tail [59:0] = data_in.
//  Reset (rst=0 at posedge): state IDLE, flit_out 0, valid_out 0, pkt_count 0; partial packet dropped.
//  flit_out/valid_out registered; pkt_ready, data_ready, busy combinational from state (and buffer_on).
//  FSM IDLE -> HEAD -> BODY -> IDLE:
//   IDLE: pkt_ready=1; on pkt_valid latch dest/len/tag, -> HEAD. No flit emitted at that edge.
//   HEAD: at posedge with buffer_on=1 emit head (len>0, -> BODY, remaining=len) or head-tail
//    (len=0, -> IDLE, pkt_count+1). buffer_on=0: hold, valid_out=0 next cycle.
//   BODY: data_ready = buffer_on; on data_valid & buffer_on emit data_in as body (remaining>1) or
//    tail (remaining==1, -> IDLE, pkt_count+1); remaining-1. Else bubble (valid_out=0).
//  valid_out is 1 only in the cycle after an emitting edge; never two flits in one cycle; flit_out
//   holds last value when valid_out=0.
//  pkt_ready=0 in HEAD/BODY; descriptor changes ignored mid-packet; data_ready=0 outside BODY.
//  Back-to-back: IDLE cycle after each tail -> min packet spacing = len+2 cycles (len+1 flits).
//  Dest == (X_CURRENT,Y_CURRENT) legal; sent unchanged (router ejects locally).
//  Max throughput 1 flit/cycle while buffer_on=1 and data_valid=1.
// TESTING
//  T1 single-flit: dest(2,1), len=0, buffer_on=1 -> one flit 0xC0000_2 style: [63:62]=11,
//     [59:57]=2,[56:54]=1,[47:44]=0, [61:60]=0; pkt_count=1; pkt_ready high next cycle.
//  T2 5-flit packet: len=4, data 1,2,3,4 streamed, buffer_on=1 -> types 00,01,01,01,10 on 5
//     consecutive valid_out cycles, payloads 1..4, pkt_count=1.
//  T3 backpressure: T2 with buffer_on=0 for 3 cycles after 2nd body -> valid_out low 3 cycles,
//     data_ready low, no flit lost/duplicated, tail payload 4.
//  T4 source stall: data_valid low 2 cycles mid-packet -> 2 bubbles, order preserved.
//  T5 reset mid-packet: rst=0 after 2nd flit of len=4 -> valid_out=0, busy=0, pkt_count=0 next
//     cycle; new len=0 packet afterwards sent with tag 00.
//  T6 tag/count wrap: 5 packets back-to-back -> tags 00,01,10,11,00; pkt_count=5;
//     force 16'hFFFF path -> wraps to 0.

Source files
------------

// File: rtl/flit_injector.sv
// Local-port network interface transmitter: turns packet descriptors plus payload words into
// wormhole flits (head/body/tail or single head-tail) for a router inport under buffer_on flow control.
module flit_injector #(
  parameter logic [2:0] X_CURRENT = 3'b000,
  parameter logic [2:0] Y_CURRENT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [2:0]  pkt_dest_x,
  input  logic [2:0]  pkt_dest_y,
  input  logic [3:0]  pkt_len,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [59:0] data_in,
  input  logic        buffer_on,
  output logic [63:0] flit_out,
  output logic        valid_out,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [1:0]  state_dbg
);

  // Handshakes: a descriptor or payload word transfers at a posedge where its valid and ready are
  // both high; a flit is pushed into the router at a posedge where buffer_on is high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_HEAD = 2'b00;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam logic [1:0] TYPE_HT   = 2'b11;

  state_t      state_q, state_d;
  logic [2:0]  dx_q, dx_d;
  logic [2:0]  dy_q, dy_d;
  logic [3:0]  len_q, len_d;
  logic [1:0]  tag_q, tag_d;
  logic [3:0]  rem_q, rem_d;
  logic [63:0] flit_q, flit_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  always_comb begin
    state_d    = state_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    len_d      = len_q;
    tag_d      = tag_q;
    rem_d      = rem_q;
    flit_d     = flit_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    pkt_ready  = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) begin
          dx_d    = pkt_dest_x;
          dy_d    = pkt_dest_y;
          len_d   = pkt_len;
          tag_d   = count_q[1:0];
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (buffer_on) begin
          valid_d = 1'b1;
          flit_d  = {(len_q == 4'd0) ? TYPE_HT : TYPE_HEAD, tag_q, dx_q, dy_q,
                     X_CURRENT, Y_CURRENT, len_q, 44'd0};
          if (len_q == 4'd0) begin
            state_d = IDLE;
            count_d = count_q + 16'd1;
          end else begin
            state_d = BODY;
            rem_d   = len_q;
          end
        end
      end
      BODY: begin
        data_ready = buffer_on;
        if (data_valid && buffer_on) begin
          valid_d = 1'b1;
          flit_d  = {(rem_q == 4'd1) ? TYPE_TAIL : TYPE_BODY, tag_q, data_in};
          rem_d   = rem_q - 4'd1;
          // Last payload word closes the packet; one IDLE cycle follows every tail.
          if (rem_q == 4'd1) begin
            state_d = IDLE;
            count_d = count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dx_q    <= 3'd0;
      dy_q    <= 3'd0;
      len_q   <= 4'd0;
      tag_q   <= 2'd0;
      rem_q   <= 4'd0;
      flit_q  <= 64'd0;
      valid_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      len_q   <= len_d;
      tag_q   <= tag_d;
      rem_q   <= rem_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign flit_out  = flit_q;
  assign valid_out = valid_q;
  assign busy      = (state_q != IDLE);
  assign pkt_count = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: directed scenarios plus randomized packets, every emitted flit checked
// in order against flits predicted from the descriptor, payload words and a packet counter model.
module tb_flit_injector;

  localparam logic [2:0] XC = 3'd5;
  localparam logic [2:0] YC = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [2:0]  pkt_dest_x = 3'd0;
  logic [2:0]  pkt_dest_y = 3'd0;
  logic [3:0]  pkt_len = 4'd0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [59:0] data_in = 60'd0;
  logic        buffer_on = 1'b0;
  logic [63:0] flit_out;
  logic        valid_out;
  logic        busy;
  logic [15:0] pkt_count;
  logic [1:0]  state_dbg;

  flit_injector #(.X_CURRENT(XC), .Y_CURRENT(YC)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dest_x(pkt_dest_x), .pkt_dest_y(pkt_dest_y), .pkt_len(pkt_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .buffer_on(buffer_on), .flit_out(flit_out), .valid_out(valid_out),
    .busy(busy), .pkt_count(pkt_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [15:0] model_count = 16'd0;
  logic [59:0] words[16];
  logic [63:0] mon_exp;

  function automatic logic [63:0] head_flit(input logic [1:0] tag, input logic [2:0] dx,
                                            input logic [2:0] dy, input logic [3:0] len);
    head_flit = {(len == 4'd0) ? 2'b11 : 2'b00, tag, dx, dy, XC, YC, len, 44'd0};
  endfunction

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL flit_unexpected: got %h, required no flit", flit_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (flit_out !== mon_exp) begin
          tests_failed++;
          $display("FAIL flit_order: got %h, required %h", flit_out, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_words(input bit seq);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) begin
      r = {$urandom, $urandom};
      words[i] = seq ? 60'(i + 1) : r[59:0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pkt_valid = 1'b0;
    data_valid = 1'b0;
    buffer_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_count = 16'd0;
    exp_q.delete();
  endtask

  // Called just after a negedge with the DUT idle; returns at the negedge where busy has dropped.
  task automatic send_pkt(input logic [2:0] dx, input logic [2:0] dy, input logic [3:0] len,
                          input int bo_pct, input int dv_pct, input int stall_at,
                          input int stall_len, input bit stall_bo, input int exp_busy);
    int idx = 0;
    int busy_cycles = 0;
    int stall_left = 0;
    int guard = 0;
    bit stalled = 1'b0;
    bit bo, dv;
    logic [1:0] tag;
    tag = model_count[1:0];
    pkt_valid = 1'b1;
    pkt_dest_x = dx;
    pkt_dest_y = dy;
    pkt_len = len;
    buffer_on = 1'b0;
    data_valid = 1'b0;
    #1;
    tests_run++;
    if (pkt_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pkt_ready_idle: got %b, required 1", pkt_ready);
    end
    exp_q.push_back(head_flit(tag, dx, dy, len));
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({(i == int'(len) - 1) ? 2'b10 : 2'b01, tag, words[i]});
    @(negedge clk);
    pkt_valid = 1'b0;
    pkt_dest_x = 3'($urandom_range(7));
    pkt_dest_y = 3'($urandom_range(7));
    pkt_len = 4'($urandom_range(15));
    while (!(idx == int'(len) && busy === 1'b0)) begin
      guard++;
      if (guard > 300) begin
        tests_run++;
        tests_failed++;
        $display("FAIL pkt_timeout: sent %0d of %0d words, required packet completion", idx, len);
        break;
      end
      busy_cycles++;
      bo = ($urandom_range(99) < bo_pct);
      dv = ($urandom_range(99) < dv_pct);
      if (stall_left > 0) begin
        if (stall_bo) bo = 1'b0;
        else dv = 1'b0;
        stall_left--;
      end
      buffer_on = bo;
      data_valid = dv && (idx < int'(len));
      data_in = (idx < int'(len)) ? words[idx] : 60'hBAD_F00D;
      #1;
      tests_run++;
      if (pkt_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL mid_pkt_flags: pkt_ready=%b busy=%b, required 0/1", pkt_ready, busy);
      end
      if (!buffer_on) begin
        tests_run++;
        if (data_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL data_ready_bp: got %b, required 0 while buffer_on=0", data_ready);
        end
      end
      if (data_valid && data_ready === 1'b1) idx++;
      if (idx == stall_at && !stalled && stall_len > 0) begin
        stalled = 1'b1;
        stall_left = stall_len;
      end
      @(negedge clk);
    end
    buffer_on = 1'b0;
    data_valid = 1'b0;
    model_count++;
    tests_run++;
    if (pkt_count !== model_count) begin
      tests_failed++;
      $display("FAIL pkt_count: got %0d, required %0d", pkt_count, model_count);
    end
    tests_run++;
    if (pkt_ready !== 1'b1 || data_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_pkt: pkt_ready=%b data_ready=%b, required 1/0", pkt_ready, data_ready);
    end
    if (exp_busy > 0) begin
      tests_run++;
      if (busy_cycles != exp_busy) begin
        tests_failed++;
        $display("FAIL pkt_cycles: got %0d busy cycles, required %0d", busy_cycles, exp_busy);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if (flit_out !== 64'd0 || valid_out !== 1'b0 || pkt_count !== 16'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: flit=%h valid=%b count=%0d busy=%b, required 0/0/0/0",
               flit_out, valid_out, pkt_count, busy);
    end
    tests_run++;
    if (pkt_ready !== 1'b1 || data_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: pkt_ready=%b data_ready=%b, required 1/0", pkt_ready, data_ready);
    end
  endtask

  task automatic test_single_flit();
    send_pkt(3'd2, 3'd1, 4'd0, 100, 100, -1, 0, 1'b0, 1);
  endtask

  task automatic test_five_flit();
    fill_words(1'b1);
    send_pkt(3'd3, 3'd4, 4'd4, 100, 100, -1, 0, 1'b0, 5);
  endtask

  task automatic test_backpressure();
    fill_words(1'b1);
    send_pkt(3'd1, 3'd7, 4'd4, 100, 100, 2, 3, 1'b1, 8);
  endtask

  task automatic test_source_stall();
    fill_words(1'b0);
    send_pkt(3'd6, 3'd2, 4'd4, 100, 100, 2, 2, 1'b0, 7);
  endtask

  task automatic test_reset_mid_packet();
    fill_words(1'b0);
    exp_q.push_back(head_flit(model_count[1:0], 3'd4, 3'd4, 4'd4));
    exp_q.push_back({2'b01, model_count[1:0], words[0]});
    pkt_valid = 1'b1;
    pkt_dest_x = 3'd4;
    pkt_dest_y = 3'd4;
    pkt_len = 4'd4;
    buffer_on = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
    data_valid = 1'b1;
    data_in = words[0];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd0 || flit_out !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_pkt: valid=%b busy=%b count=%0d flit=%h, required 0/0/0/0",
               valid_out, busy, pkt_count, flit_out);
    end
    rst = 1'b1;
    buffer_on = 1'b0;
    model_count = 16'd0;
    send_pkt(3'd0, 3'd5, 4'd0, 100, 100, -1, 0, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] len;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      fill_words(1'b0);
      len = 4'($urandom_range(3));
      send_pkt(3'($urandom_range(7)), 3'($urandom_range(7)), len, 100, 100, -1, 0, 1'b0,
               int'(len) + 1);
    end
    tests_run++;
    if (pkt_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d, required 5", pkt_count);
    end
  endtask

  task automatic test_local_dest();
    fill_words(1'b0);
    send_pkt(XC, YC, 4'd2, 100, 100, -1, 0, 1'b0, 3);
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      fill_words(1'b0);
      send_pkt(3'($urandom_range(7)), 3'($urandom_range(7)), 4'($urandom_range(15)),
               70, 70, -1, 0, 1'b0, 0);
    end
  endtask

  task automatic test_count_wrap();
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.count_q;
    model_count = 16'hFFFF;
    tests_run++;
    if (pkt_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_preset: got %h, required ffff", pkt_count);
    end
    send_pkt(3'd7, 3'd0, 4'd0, 100, 100, -1, 0, 1'b0, 1);
    fill_words(1'b0);
    send_pkt(3'd2, 3'd3, 4'd1, 100, 100, -1, 0, 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_five_flit();
    test_backpressure();
    test_source_stall();
    test_reset_mid_packet();
    test_back_to_back();
    test_local_dest();
    test_random();
    test_count_wrap();
    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL flits_missing: %0d flits never emitted, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
